scan_display_ctrl: RTL and testbench

Time-multiplexed seven-segment scan controller for the board display. Generalises the fixed 4-digit scan selector to a parametrised digit count and adds an internal refresh prescaler, a tear-free shadow buffer loaded by handshake, per-digit blanking and optional blinking. It sits between the CPU-side display registers and the hex-to-segment decoder/anode pins.

---
 rtl/scan_display_if.sv | 15 +
 rtl/scan_display_ctrl.sv | 148 ++++++++++++++
 tb/tb_scan_display_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/scan_display_if.sv
// CPU-side load bus for scan_display_ctrl: per-digit nibbles, points, blank
// and blink masks, plus the load / load_ack handshake.
interface scan_display_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] hexs;
  logic [DIGITS-1:0]   points;
  logic [DIGITS-1:0]   les;
  logic [DIGITS-1:0]   blinks;
  logic                load;
  logic                load_ack;

  modport master (output hexs, points, les, blinks, load, input load_ack);
  modport slave  (input hexs, points, les, blinks, load, output load_ack);
endinterface

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed seven-segment scan controller with refresh prescaler,
// frame-aligned shadow buffer, per-digit blanking and optional blinking.
// Optional feature macro: SCAN_BLINK_EN (blink frame counter + blink_phase).

// Per-digit blank decision: dark when blanked, or blinking in the off phase.
module scan_digit_blank (
  input  logic le_bit,
  input  logic blink_bit,
  input  logic phase,
  output logic blank
);
  assign blank = le_bit | (blink_bit & phase);
endmodule

module scan_display_ctrl #(
  parameter  int DIGITS       = 8,
  parameter  int SCAN_DIV     = 16,
  parameter  int BLINK_FRAMES = 64,
  localparam int SEL_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  scan_display_if.slave      bus,
  output logic [SEL_W-1:0]   scan,
  output logic [3:0]         hexo,
  output logic               p,
  output logic               le,
  output logic [DIGITS-1:0]  an,
  output logic               frame_done
);
  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  logic [DIV_W-1:0]       div_cnt;
  logic [DIGITS-1:0][3:0] sh_hex, sh_hex_nxt;
  logic [DIGITS-1:0]      sh_pt, sh_pt_nxt, sh_le, sh_le_nxt;
  logic [DIGITS-1:0]      bl_gate, blank_nxt;
  logic [DIGITS-1:0]      an_nxt;
  logic [SEL_W-1:0]       scan_nxt;
  logic                   load_pending, load_q;
  logic                   tc, wrap, req, capture;
  logic                   phase_nxt;

  assign tc      = (div_cnt == DIV_LAST);
  assign wrap    = tc && (scan == SEL_LAST);
  // Only a rising load is a new request, so a held load never re-triggers.
  assign req     = bus.load & ~load_q;
  assign capture = wrap & (load_pending | req);

  // Next digit index: advance on terminal count, wrap at the last digit.
  always_comb begin
    scan_nxt = scan;
    if (tc) scan_nxt = (scan == SEL_LAST) ? '0 : scan + SEL_W'(1);
  end

  // Next shadow contents: inputs captured only on the frame-boundary edge.
  always_comb begin
    sh_hex_nxt = sh_hex;
    sh_pt_nxt  = sh_pt;
    sh_le_nxt  = sh_le;
    if (capture) begin
      sh_hex_nxt = bus.hexs;
      sh_pt_nxt  = bus.points;
      sh_le_nxt  = bus.les;
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0]   fcnt;
  logic              phase;
  logic [DIGITS-1:0] sh_bl, sh_bl_nxt;

  assign sh_bl_nxt = capture ? bus.blinks : sh_bl;
  assign phase_nxt = (wrap && fcnt == FC_LAST) ? ~phase : phase;
  assign bl_gate   = sh_bl_nxt;

  // Frame counter and blink phase, stepped once per frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
      sh_bl <= '0;
    end else begin
      sh_bl <= sh_bl_nxt;
      phase <= phase_nxt;
      if (wrap) fcnt <= (fcnt == FC_LAST) ? '0 : fcnt + FC_W'(1);
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{bus.blinks, (BLINK_FRAMES > 0)};
  assign phase_nxt    = 1'b0;
  assign bl_gate      = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    scan_digit_blank u_blank (
      .le_bit    (sh_le_nxt[i]),
      .blink_bit (bl_gate[i]),
      .phase     (phase_nxt),
      .blank     (blank_nxt[i])
    );
  end

  // Anode pattern for the next slot: one low bit when lit, all high when dark.
  always_comb begin
    an_nxt = '1;
    if (!blank_nxt[scan_nxt]) an_nxt[scan_nxt] = 1'b0;
  end

  // Prescaler, scan index, shadow, handshake and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      scan         <= '0;
      sh_hex       <= '0;
      sh_pt        <= '0;
      sh_le        <= '1;
      load_pending <= 1'b0;
      load_q       <= 1'b0;
      bus.load_ack <= 1'b0;
      frame_done   <= 1'b0;
      hexo         <= '0;
      p            <= 1'b0;
      le           <= 1'b1;
      an           <= '1;
    end else begin
      div_cnt      <= tc ? '0 : div_cnt + DIV_W'(1);
      scan         <= scan_nxt;
      sh_hex       <= sh_hex_nxt;
      sh_pt        <= sh_pt_nxt;
      sh_le        <= sh_le_nxt;
      load_q       <= bus.load;
      if (capture)  load_pending <= 1'b0;
      else if (req) load_pending <= 1'b1;
      bus.load_ack <= capture;
      frame_done   <= wrap;
      hexo         <= sh_hex_nxt[scan_nxt];
      p            <= sh_pt_nxt[scan_nxt];
      le           <= blank_nxt[scan_nxt];
      an           <= an_nxt;
    end
  end
endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl with DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2; outputs sampled on the falling clock edge.
module tb_scan_display_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] scan;
  logic [3:0] hexo;
  logic       p, le, frame_done;
  logic [3:0] an;
  int         nvec = 0, nfail = 0;

  scan_display_if #(.DIGITS(4)) bus ();

  scan_display_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .scan       (scan),
    .hexo       (hexo),
    .p          (p),
    .le         (le),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     hexs;
    logic [3:0]      pts, les, bls;
    logic [3:0][3:0] an_e;
    logic [3:0][3:0] hx_e;
    logic [3:0]      p_e, le_e;
  } vec_t;

  vec_t tbl[4];
  vec_t dark;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check one full frame starting at the current (frame-start) negedge.
  task automatic check_frame(input vec_t e, input logic ack_exp);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      chk("scan", 16'(scan), 16'(k / 4));
      chk("frame_done", 16'(frame_done), 16'(k == 0));
      chk("load_ack", 16'(bus.load_ack), 16'(ack_exp && k == 0));
      chk("an", 16'(an), 16'(e.an_e[k/4]));
      chk("hexo", 16'(hexo), 16'(e.hx_e[k/4]));
      chk("p", 16'(p), 16'(e.p_e[k/4]));
      chk("le", 16'(le), 16'(e.le_e[k/4]));
    end
  endtask

  // Pulse load, check old data until load_ack, then check the new frame.
  task automatic apply(input vec_t e, input vec_t prev);
    int lat;
    bus.hexs = e.hexs; bus.points = e.pts; bus.les = e.les; bus.blinks = e.bls;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    lat = 1;
    while (!bus.load_ack && lat <= 40) begin
      chk("old_an", 16'(an), 16'(prev.an_e[scan]));
      chk("old_hexo", 16'(hexo), 16'(prev.hx_e[scan]));
      @(negedge clk);
      lat++;
    end
    chk("ack_in_window", 16'(lat <= 17), 16'd1);
    if (lat <= 40) check_frame(e, 1'b1);
  endtask

  initial begin
    logic lit[8];
    int   acks;
    tbl[0] = '{16'h1234, 4'b0101, 4'b0000, 4'b0000,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 16'h1234, 4'b0101, 4'b0000};
    tbl[1] = '{16'hABCD, 4'b1010, 4'b0010, 4'b0000,
               {4'b0111, 4'b1011, 4'b1111, 4'b1110}, 16'hABCD, 4'b1010, 4'b0010};
    tbl[2] = '{16'h0F0F, 4'b1111, 4'b1111, 4'b0000,
               {4'b1111, 4'b1111, 4'b1111, 4'b1111}, 16'h0F0F, 4'b1111, 4'b1111};
    tbl[3] = '{16'h9876, 4'b0000, 4'b1001, 4'b0001,
               {4'b1111, 4'b1011, 4'b1101, 4'b1111}, 16'h9876, 4'b0000, 4'b1001};
    dark   = '{16'h0000, 4'b0000, 4'b1111, 4'b0000,
               {4'b1111, 4'b1111, 4'b1111, 4'b1111}, 16'h0000, 4'b0000, 4'b1111};

    bus.hexs = '0; bus.points = '0; bus.les = '0; bus.blinks = '0; bus.load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_le", 16'(le), 16'd1);
    chk("rst_scan", 16'(scan), 16'd0);
    chk("rst_hexo", 16'(hexo), 16'd0);
    chk("rst_p", 16'(p), 16'd0);
    chk("rst_ack", 16'(bus.load_ack), 16'd0);
    chk("rst_fd", 16'(frame_done), 16'd0);
    rst_n = 1'b1;

    // Scan cadence while dark: 4 cycles per digit, first wrap after 16 edges
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("cad_scan", 16'(scan), 16'((k / 4) % 4));
      chk("cad_fd", 16'(frame_done), 16'(k == 16));
      chk("cad_an", 16'(an), 16'hF);
    end

    // Table-driven loads; each frame before the ack must still show old data
    for (int v = 0; v < 4; v++) apply(tbl[v], (v == 0) ? dark : tbl[v-1]);

    // New inputs without load never reach the outputs
    @(negedge clk);
    bus.hexs = 16'hABCD; bus.points = 4'b1111; bus.les = 4'b0000;
    check_frame(tbl[3], 1'b0);
    @(negedge clk);
    check_frame(tbl[3], 1'b0);

    // Load raised just before the boundary edge: ack on the very next cycle
    bus.hexs = 16'hABCD; bus.points = 4'b1010; bus.les = 4'b0010; bus.blinks = '0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("boundary_ack", 16'(bus.load_ack), 16'd1);
    check_frame(tbl[1], 1'b1);

    // Blinking digit 0
    bus.hexs = 16'h1234; bus.points = 4'b0000; bus.les = 4'b0000; bus.blinks = 4'b0001;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("blink_ack", 16'(bus.load_ack), 16'd1);
    for (int f = 0; f < 8; f++) begin
      chk("blink_fd", 16'(frame_done), 16'd1);
      lit[f] = (an == 4'b1110);
      repeat (4) @(negedge clk);
      chk("blink_d1", 16'(an), 16'b1101);
      repeat (12) @(negedge clk);
    end
`ifdef SCAN_BLINK_EN
    for (int f = 0; f < 6; f++) chk("blink_period", 16'(lit[f+2]), 16'(!lit[f]));
    for (int f = 0; f < 7; f++) chk("blink_pairs", 16'(lit[f] == lit[f+1]), 16'(f % 2 == (lit[0] == lit[1] ? 0 : 1)));
`else
    for (int f = 0; f < 8; f++) chk("noblink_lit", 16'(lit[f]), 16'd1);
`endif

    // Reset during scan=2 with a load pending
    repeat (8) @(negedge clk);
    chk("pre_rst_scan", 16'(scan), 16'd2);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_an", 16'(an), 16'hF);
    chk("midrst_scan", 16'(scan), 16'd0);
    chk("midrst_le", 16'(le), 16'd1);
    chk("midrst_hexo", 16'(hexo), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.load_ack) acks++;
    end
    chk("no_ack_after_rst", 16'(acks), 16'd0);
    chk("dark_after_rst", 16'(an), 16'hF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
